// File: rtl/fpu_addsub_param.sv
`default_nettype none
// fpu_addsub_param: parametrised multi-cycle {sign, exp, man} add/subtract, RNE rounding.
// Rev 1.0 -- valid/ready on both sides, one transaction in flight at a time.
module fpu_addsub_param #(
  parameter  int EXP_W = 10,
  parameter  int MAN_W = 21,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100Khz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [1:0]   status_out
);

  localparam int MW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [1:0] ST_OVF   = 2'd0;
  localparam logic [1:0] ST_UNF   = 2'd1;
  localparam logic [1:0] ST_EXACT = 2'd2;
  localparam logic [1:0] ST_INEX  = 2'd3;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  typedef enum logic [2:0] {IDLE, ALIGN, OPERATE, NORMALIZE, ROUND, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]         a_q, a_d, b_q, b_d, data_q, data_d;
  logic                 sub_q, sub_d, sign_q, sign_d, effsub_q, effsub_d;
  logic                 inf_q, inf_d, zero_q, zero_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d, norm_q, norm_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [1:0]           status_q, status_d;

  logic                 sa, sb, za, zb, ia, ib, a_big, sticky, found, up;
  logic                 ovf, unf, inexact;
  logic [EXP_W-1:0]     ea, eb, e_big, shift;
  logic [MAN_W-1:0]     fa, fb, man_r;
  logic [MW-1:0]        m_big, m_sml, shifted, aligned;
  logic [LZW-1:0]       lzc;
  logic [MAN_W+1:0]     rnd;
  logic signed [XW-1:0] exp_r;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign data_out   = data_q;
  assign status_out = status_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_valid) state_d = ALIGN;
      ALIGN:     state_d = OPERATE;
      OPERATE:   state_d = NORMALIZE;
      NORMALIZE: state_d = ROUND;
      ROUND:     state_d = DONE;
      DONE:      if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    // Zero operands drop their mantissa so they never win the magnitude compare.
    sa    = a_q[W-1];
    sb    = b_q[W-1] ^ sub_q;
    ea    = a_q[W-2 -: EXP_W];
    eb    = b_q[W-2 -: EXP_W];
    za    = (ea == '0);
    zb    = (eb == '0);
    ia    = &ea;
    ib    = &eb;
    fa    = za ? '0 : a_q[MAN_W-1:0];
    fb    = zb ? '0 : b_q[MAN_W-1:0];
    a_big = ({ea, fa} >= {eb, fb});
    e_big = a_big ? ea : eb;
    shift = a_big ? (ea - eb) : (eb - ea);
    m_big = a_big ? {~za, fa, 3'b000} : {~zb, fb, 3'b000};
    m_sml = a_big ? {~zb, fb, 3'b000} : {~za, fa, 3'b000};
    shifted = m_sml >> shift;
    sticky  = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (EXP_W'(i) < shift) sticky = sticky | m_sml[i];
    end
    if (shift >= EXP_W'(MAN_W + 3)) aligned = {{(MW-1){1'b0}}, |m_sml};
    else                            aligned = {shifted[MW-1:1], shifted[0] | sticky};

    lzc   = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum_q[i]) found = 1'b1;
        else          lzc   = lzc + LZW'(1);
      end
    end

    up      = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    rnd     = {1'b0, norm_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    exp_r   = exp_q + XW'(rnd[MAN_W+1]);
    man_r   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    inexact = |norm_q[2:0];
    ovf     = inf_q | (!zero_q && (exp_r >= EXP_MAX));
    unf     = !zero_q && (exp_r <= EXP_ZERO);

    a_d = a_q;  b_d = b_q;  sub_d = sub_q;  sign_d = sign_q;  effsub_d = effsub_q;
    inf_d = inf_q;  zero_d = zero_q;  exp_d = exp_q;  ma_d = ma_q;  mb_d = mb_q;
    sum_d = sum_q;  norm_d = norm_q;  data_d = data_q;  status_d = status_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d   = op_a;
        b_d   = op_b;
        sub_d = op_sub;
      end
      ALIGN: begin
        ma_d     = m_big;
        mb_d     = aligned;
        exp_d    = XW'(e_big);
        effsub_d = sa ^ sb;
        inf_d    = ia | ib;
        sign_d   = (ia & ib) ? sa : (a_big ? sa : sb);
      end
      OPERATE: sum_d = effsub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
      NORMALIZE: begin
        zero_d = (sum_q == '0);
        if (sum_q[SW-1]) begin
          norm_d = {sum_q[SW-1:2], |sum_q[1:0]};
          exp_d  = exp_q + XW'(1);
        end else begin
          norm_d = sum_q[MW-1:0] << lzc;
          exp_d  = exp_q - XW'(lzc);
        end
      end
      ROUND: begin
        if (ovf) begin
          data_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          status_d = ST_OVF;
        end else if (unf) begin
          data_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          status_d = ST_UNF;
        end else if (zero_q) begin
          data_d   = '0;
          status_d = ST_EXACT;
        end else begin
          data_d   = {sign_q, exp_r[EXP_W-1:0], man_r};
          status_d = inexact ? ST_INEX : ST_EXACT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      a_q <= '0;  b_q <= '0;  sub_q <= 1'b0;  sign_q <= 1'b0;  effsub_q <= 1'b0;
      inf_q <= 1'b0;  zero_q <= 1'b0;  exp_q <= '0;  ma_q <= '0;  mb_q <= '0;
      sum_q <= '0;  norm_q <= '0;  data_q <= '0;  status_q <= ST_EXACT;
    end else begin
      a_q <= a_d;  b_q <= b_d;  sub_q <= sub_d;  sign_q <= sign_d;  effsub_q <= effsub_d;
      inf_q <= inf_d;  zero_q <= zero_d;  exp_q <= exp_d;  ma_q <= ma_d;  mb_q <= mb_d;
      sum_q <= sum_d;  norm_q <= norm_d;  data_q <= data_d;  status_q <= status_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fpu_addsub_param: vector table plus backpressure and mid-flight reset sequences.
module tb_fpu_addsub_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;
  logic [1:0]  status_out;

  always #5 clk = ~clk;

  fpu_addsub_param #(.EXP_W(10), .MAN_W(21)) dut (
    .clock_100Khz(clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_sub      (op_sub),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] d;
    logic [1:0]  st;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  st;
  } exp_t;

  localparam logic [1:0] OVF = 2'd0, UNF = 2'd1, EXACT = 2'd2, INEX = 2'd3;
  localparam int NV = 15;

  vec_t vecs[NV];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drives one transaction with out_ready held high and checks latency, result and hold.
  task automatic run_txn(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    @(negedge clk);
    out_ready = 1'b1;
    op_a = v.a;  op_b = v.b;  op_sub = v.sub;  in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    e.d = v.d;  e.st = v.st;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;  op_a = ~v.a;  op_b = ~v.b;  op_sub = ~v.sub;
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    got = sb.pop_front();
    chk({tag, "_data"}, data_out, got.d);
    chk({tag, "_status"}, 32'(status_out), 32'(got.st));
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_data_hold"}, data_out, got.d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    exp_t e;
    exp_t got;
    int   lat;

    vecs[0]  = '{32'h3FE00000, 32'h3FE00000, 1'b0, 32'h40000000, EXACT};
    vecs[1]  = '{32'h3FE00000, 32'h3FE00000, 1'b1, 32'h00000000, EXACT};
    vecs[2]  = '{32'h3FE00000, 32'h40100000, 1'b0, 32'h40200000, EXACT};
    vecs[3]  = '{32'h3FE00000, 32'h3D200000, 1'b0, 32'h3FE00000, INEX};
    vecs[4]  = '{32'h7FDFFFFF, 32'h7FDFFFFF, 1'b0, 32'h7FE00000, OVF};
    vecs[5]  = '{32'h00300000, 32'h00200000, 1'b1, 32'h00000000, UNF};
    vecs[6]  = '{32'h3FE00000, 32'hBFE00000, 1'b0, 32'h00000000, EXACT};
    vecs[7]  = '{32'h40000000, 32'h40100000, 1'b1, 32'hBFE00000, EXACT};
    vecs[8]  = '{32'h7FE00000, 32'h3FE00000, 1'b0, 32'h7FE00000, OVF};
    vecs[9]  = '{32'hFFE00000, 32'h7FE00000, 1'b1, 32'hFFE00000, OVF};
    vecs[10] = '{32'h00000000, 32'h3FE00000, 1'b0, 32'h3FE00000, EXACT};
    vecs[11] = '{32'h3FE00000, 32'h3C200000, 1'b0, 32'h3FE00000, INEX};
    vecs[12] = '{32'h3FE00000, 32'h3D300000, 1'b0, 32'h3FE00001, INEX};
    vecs[13] = '{32'h3FE00001, 32'h3D200000, 1'b0, 32'h3FE00002, INEX};
    vecs[14] = '{32'h3FE00000, 32'h3C200000, 1'b1, 32'h3FE00000, INEX};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_status", 32'(status_out), 32'(EXACT));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must sit still in DONE while a stray in_valid is ignored.
    @(negedge clk);
    out_ready = 1'b0;
    op_a = 32'h3FE00000;  op_b = 32'h40100000;  op_sub = 1'b0;  in_valid = 1'b1;
    @(posedge clk);
    e.d = 32'h40200000;  e.st = EXACT;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd4);
    got = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", data_out, got.d);
      chk("bp_status", 32'(status_out), 32'(got.st));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (i == 3) begin
        in_valid = 1'b1;  op_a = 32'h7FE00000;  op_b = 32'h7FE00000;  op_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_data", data_out, got.d);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bp_no_ghost", 32'(out_valid), 32'd0);
    end

    // Mid-flight reset: leave a non-reset result on the outputs first.
    run_txn(vecs[3], "pre_rst");
    @(negedge clk);
    op_a = 32'h3FE00000;  op_b = 32'h40100000;  op_sub = 1'b0;  in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_status", 32'(status_out), 32'(EXACT));
    @(posedge clk);
    #1;
    chk("mid_rst_held_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_discard", 32'(out_valid), 32'd0);
    end
    run_txn(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
